seg7_scan_decoder: RTL and testbench

//  Inverse of the 7-seg digit encoder: samples a time-multiplexed, active-low 7-seg bus (seg[6:0] = g..a, 0 = lit)

---
 rtl/seg7_pkg.sv | 57 +++++
 rtl/seg7_stab_filter.sv | 69 ++++++
 rtl/seg7_scan_decoder.sv | 121 ++++++++++++
 tb/tb_seg7_scan_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph constants and the segment-to-BCD decode for the 7-seg scan decoder.
// SEG7_ALT_GLYPH_EN: when defined, the alternate 6/7/9 glyphs also decode as legal digits.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  // Active-low, bit6 = g .. bit0 = a
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1011000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0011000;

`ifdef SEG7_ALT_GLYPH_EN
  localparam logic [6:0] GLYPH_6_ALT = 7'b0000011;
  localparam logic [6:0] GLYPH_7_ALT = 7'b1111000;
  localparam logic [6:0] GLYPH_9_ALT = 7'b0010000;
`endif

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] bcd;
  } seg7_dec_t;

  function automatic seg7_dec_t seg7_to_bcd(input logic [6:0] seg);
    seg7_dec_t r;
    r = '{legal: 1'b1, blank: 1'b0, bcd: BCD_INVALID};
    case (seg)
      GLYPH_0:     r.bcd = 4'd0;
      GLYPH_1:     r.bcd = 4'd1;
      GLYPH_2:     r.bcd = 4'd2;
      GLYPH_3:     r.bcd = 4'd3;
      GLYPH_4:     r.bcd = 4'd4;
      GLYPH_5:     r.bcd = 4'd5;
      GLYPH_6:     r.bcd = 4'd6;
      GLYPH_7:     r.bcd = 4'd7;
      GLYPH_8:     r.bcd = 4'd8;
      GLYPH_9:     r.bcd = 4'd9;
`ifdef SEG7_ALT_GLYPH_EN
      GLYPH_6_ALT: r.bcd = 4'd6;
      GLYPH_7_ALT: r.bcd = 4'd7;
      GLYPH_9_ALT: r.bcd = 4'd9;
`endif
      SEG_BLANK:   r.blank = 1'b1;
      default:     r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_stab_filter.sv
// Per-digit stability filter: tracks a candidate pattern, counts repeats and commits
// the decoded code once the pattern has been seen STABLE_CNT times in a row.
module seg7_stab_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample,
  input  logic [6:0] seg_in,
  input  seg7_dec_t  dec,
  output logic       commit_evt,
  output logic       commit_bad,
  output logic [3:0] bcd
);

  localparam logic [3:0] STABLE    = 4'(STABLE_CNT);
  localparam logic [3:0] STABLE_M1 = 4'(STABLE_CNT - 1);

  logic [6:0] cand_q, cand_d;
  logic [3:0] count_q, count_d;
  logic [3:0] bcd_q, bcd_d;
  logic       blank_q, blank_d;
  logic       commit;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    cand_d  = cand_q;
    count_d = count_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    commit  = 1'b0;
    if (sample) begin
      if (seg_in != cand_q) begin
        cand_d  = seg_in;
        count_d = 4'd1;
      end else if (count_q != STABLE) begin
        count_d = count_q + 4'd1;
        commit  = (count_q == STABLE_M1);
      end
    end
    if (commit) begin
      bcd_d   = dec.bcd;
      blank_d = dec.blank;
    end
  end

  // Only a change of the committed (bcd, blank) code is worth an event
  assign commit_evt = commit && ((dec.bcd != bcd_q) || (dec.blank != blank_q));
  assign commit_bad = commit && !dec.legal;
  assign bcd        = bcd_q;

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
    if (reset) begin
      cand_q  <= SEG_BLANK;
      count_q <= 4'd0;
      bcd_q   <= BCD_INVALID;
      blank_q <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      count_q <= count_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed active-low 7-seg bus and publishes changes as events.
// SEG7_ALT_GLYPH_EN (see seg7_pkg) enables the alternate 6/7/9 glyphs.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_idx,
  output logic [3:0]              out_bcd,
  output logic                    out_blank,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic                    err_pattern,
  output logic                    err_sel,
  output logic                    overflow,
  input  logic                    err_clr
);

  seg7_dec_t             dec;
  logic                  sel_onehot;
  logic                  sel_bad;
  logic [NUM_DIGITS-1:0] evt;
  logic [NUM_DIGITS-1:0] bad;
  logic                  any_evt;
  logic [2:0]            ev_idx;

  logic       out_valid_q, out_valid_d;
  logic [2:0] out_idx_q, out_idx_d;
  logic [3:0] out_bcd_q, out_bcd_d;
  logic       out_blank_q, out_blank_d;
  logic       err_pattern_q, err_pattern_d;
  logic       err_sel_q, err_sel_d;
  logic       overflow_q, overflow_d;
  logic       ovf_set;

  assign dec        = seg7_to_bcd(seg_in);
  assign sel_onehot = (digit_sel != '0) && ((digit_sel & (digit_sel - NUM_DIGITS'(1))) == '0);
  assign sel_bad    = sample_en && !sel_onehot;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    seg7_stab_filter #(.STABLE_CNT(STABLE_CNT)) u_filter (
      .clock      (clock),
      .reset      (reset),
      .sample     (sample_en & sel_onehot & digit_sel[i]),
      .seg_in     (seg_in),
      .dec        (dec),
      .commit_evt (evt[i]),
      .commit_bad (bad[i]),
      .bcd        (digits_bcd[4*i +: 4])
    );
  end

  // One-hot select means at most one digit can commit in any cycle
  assign any_evt = |evt;
  always_comb begin
    ev_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (evt[i]) ev_idx = 3'(i);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_bcd_d   = out_bcd_q;
    out_blank_d = out_blank_q;
    ovf_set     = 1'b0;
    if (any_evt) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_idx_d   = ev_idx;
        out_bcd_d   = dec.bcd;
        out_blank_d = dec.blank;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // A new error in the clear cycle keeps the flag set
    err_pattern_d = (err_pattern_q & ~err_clr) | (|bad);
    err_sel_d     = (err_sel_q & ~err_clr) | sel_bad;
    overflow_d    = (overflow_q & ~err_clr) | ovf_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_idx_q     <= 3'd0;
      out_bcd_q     <= BCD_INVALID;
      out_blank_q   <= 1'b0;
      err_pattern_q <= 1'b0;
      err_sel_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_idx_q     <= out_idx_d;
      out_bcd_q     <= out_bcd_d;
      out_blank_q   <= out_blank_d;
      err_pattern_q <= err_pattern_d;
      err_sel_q     <= err_sel_d;
      overflow_q    <= overflow_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_idx     = out_idx_q;
  assign out_bcd     = out_bcd_q;
  assign out_blank   = out_blank_q;
  assign err_pattern = err_pattern_q;
  assign err_sel     = err_sel_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios followed by random scan traffic,
// every cycle compared against a run-length reference model of the display.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 3;

  localparam logic [6:0] GLYPH [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0011000
  };
  localparam logic [6:0] POOL [15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0011000,
    7'b1111111, 7'b1010101, 7'b0000011, 7'b1111000, 7'b0010000
  };

  logic            clock = 1'b0;
  logic            reset;
  logic            sample_en;
  logic [6:0]      seg_in;
  logic [ND-1:0]   digit_sel;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_idx;
  logic [3:0]      out_bcd;
  logic            out_blank;
  logic [4*ND-1:0] digits_bcd;
  logic            err_pattern;
  logic            err_sel;
  logic            overflow;
  logic            err_clr;

  always #5 clock = ~clock;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_en   (sample_en),
    .seg_in      (seg_in),
    .digit_sel   (digit_sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_bcd     (out_bcd),
    .out_blank   (out_blank),
    .digits_bcd  (digits_bcd),
    .err_pattern (err_pattern),
    .err_sel     (err_sel),
    .overflow    (overflow),
    .err_clr     (err_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: run length of identical samples per digit, committed code per digit
  logic [6:0] last_pat [ND];
  int         run      [ND];
  logic [3:0] m_bcd    [ND];
  logic       m_blank  [ND];
  logic       e_valid, e_blank, e_pat, e_sel, e_ovf;
  logic [2:0] e_idx;
  logic [3:0] e_bcd;

  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    if (p == 7'h7F) return {2'b11, 4'hF};
    for (int d = 0; d < 10; d++) if (p == GLYPH[d]) return {2'b10, 4'(d)};
`ifdef SEG7_ALT_GLYPH_EN
    if (p == 7'b0000011) return {2'b10, 4'd6};
    if (p == 7'b1111000) return {2'b10, 4'd7};
    if (p == 7'b0010000) return {2'b10, 4'd9};
`endif
    return {2'b00, 4'hF};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      last_pat[i] = 7'h7F;
      run[i]      = 0;
      m_bcd[i]    = 4'hF;
      m_blank[i]  = 1'b0;
    end
    e_valid = 1'b0; e_idx = 3'd0; e_bcd = 4'hF; e_blank = 1'b0;
    e_pat = 1'b0; e_sel = 1'b0; e_ovf = 1'b0;
  endtask

  task automatic model_step();
    logic       set_pat, set_ovf, set_sel, ev;
    logic [5:0] d;
    int         idx;
    if (reset) begin
      model_reset();
      return;
    end
    set_pat = 1'b0; set_ovf = 1'b0; set_sel = 1'b0; ev = 1'b0; d = '0; idx = 0;
    if (sample_en) begin
      if ($countones(digit_sel) != 1) begin
        set_sel = 1'b1;
      end else begin
        for (int k = 0; k < ND; k++) if (digit_sel[k]) idx = k;
        if (seg_in == last_pat[idx]) run[idx]++;
        else begin
          last_pat[idx] = seg_in;
          run[idx]      = 1;
        end
        if (run[idx] == SC) begin
          d = ref_decode(seg_in);
          if (!d[5]) set_pat = 1'b1;
          if (d[3:0] != m_bcd[idx] || d[4] != m_blank[idx]) ev = 1'b1;
          m_bcd[idx]   = d[3:0];
          m_blank[idx] = d[4];
        end
      end
    end
    if (ev) begin
      if (!e_valid || out_ready) begin
        e_valid = 1'b1; e_idx = 3'(idx); e_bcd = d[3:0]; e_blank = d[4];
      end else begin
        set_ovf = 1'b1;
      end
    end else if (e_valid && out_ready) begin
      e_valid = 1'b0;
    end
    e_pat = (e_pat && !err_clr) || set_pat;
    e_sel = (e_sel && !err_clr) || set_sel;
    e_ovf = (e_ovf && !err_clr) || set_ovf;
  endtask

  task automatic compare_all();
    logic [4*ND-1:0] exp_digits;
    for (int i = 0; i < ND; i++) exp_digits[4*i +: 4] = m_bcd[i];
    check("out_valid", 32'(out_valid), 32'(e_valid));
    if (e_valid) begin
      check("out_idx", 32'(out_idx), 32'(e_idx));
      check("out_bcd", 32'(out_bcd), 32'(e_bcd));
      check("out_blank", 32'(out_blank), 32'(e_blank));
    end
    check("digits_bcd", 32'(digits_bcd), 32'(exp_digits));
    check("err_pattern", 32'(err_pattern), 32'(e_pat));
    check("err_sel", 32'(err_sel), 32'(e_sel));
    check("overflow", 32'(overflow), 32'(e_ovf));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic se, input logic [ND-1:0] sel, input logic [6:0] seg);
    sample_en = se;
    digit_sel = sel;
    seg_in    = seg;
    tick();
  endtask

  task automatic samp(input int idx, input logic [6:0] pat, input int n);
    logic [ND-1:0] s;
    s = '0;
    s[idx] = 1'b1;
    repeat (n) drive(1'b1, s, pat);
  endtask

  task automatic idle();
    drive(1'b0, '0, 7'h7F);
  endtask

  logic [6:0] tb_last [ND];

  initial begin
    reset = 1'b1; sample_en = 1'b0; digit_sel = '0; seg_in = 7'h7F;
    out_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_digits", 32'(digits_bcd), 32'hFFFF);
    check("rst_bcd", 32'(out_bcd), 32'hF);
    reset = 1'b0;

    // 1: digit0 shows "2"
    samp(0, 7'b0100100, 3);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_idx", 32'(out_idx), 32'd0);
    check("t1_bcd", 32'(out_bcd), 32'd2);
    check("t1_digit0", 32'(digits_bcd[3:0]), 32'd2);
    out_ready = 1'b1;
    idle();

    // 2: unstable "3" then stable "5" on digit1
    samp(1, 7'b0110000, 2);
    samp(1, 7'b0010010, 2);
    check("t2_noevt", 32'(out_valid), 32'd0);
    samp(1, 7'b0010010, 1);
    check("t2_bcd", 32'(out_bcd), 32'd5);
    check("t2_idx", 32'(out_idx), 32'd1);
    idle();

    // 3: illegal pattern on digit0
    samp(0, 7'b1010101, 3);
    check("t3_errpat", 32'(err_pattern), 32'd1);
    check("t3_digit0", 32'(digits_bcd[3:0]), 32'hF);
    check("t3_bcd", 32'(out_bcd), 32'hF);
    check("t3_blank", 32'(out_blank), 32'd0);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    check("t3_clr", 32'(err_pattern), 32'd0);

    // 4: overflow with a stalled consumer, then no overflow when ready in the commit cycle
    out_ready = 1'b0;
    samp(2, 7'b0011001, 3);
    samp(3, 7'b1111001, 3);
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_held_idx", 32'(out_idx), 32'd2);
    check("t4_held_bcd", 32'(out_bcd), 32'd4);
    err_clr = 1'b1; out_ready = 1'b1;
    idle();
    err_clr = 1'b0; out_ready = 1'b0;
    samp(2, 7'b0000000, 3);
    samp(3, 7'b1011000, 2);
    out_ready = 1'b1;
    samp(3, 7'b1011000, 1);
    check("t4_no_ovf", 32'(overflow), 32'd0);
    check("t4_new_idx", 32'(out_idx), 32'd3);
    check("t4_new_bcd", 32'(out_bcd), 32'd7);
    idle();

    // 5: bad select leaves counts alone; reset mid-count
    samp(1, 7'b0000010, 2);
    drive(1'b1, 4'b0110, 7'b0000010);
    check("t5_errsel", 32'(err_sel), 32'd1);
    samp(1, 7'b0000010, 1);
    check("t5_valid", 32'(out_valid), 32'd1);
    check("t5_bcd", 32'(out_bcd), 32'd6);
    samp(2, 7'b1000000, 2);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("t5_rst_digits", 32'(digits_bcd), 32'hFFFF);
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    samp(2, 7'b1000000, 1);
    check("t5_count_cleared", 32'(out_valid), 32'd0);

    // 6: alternate "7" glyph
    samp(0, 7'b1111000, 3);
`ifdef SEG7_ALT_GLYPH_EN
    check("t6_bcd", 32'(out_bcd), 32'd7);
    check("t6_errpat", 32'(err_pattern), 32'd0);
`else
    check("t6_errpat", 32'(err_pattern), 32'd1);
    check("t6_digit0", 32'(digits_bcd[3:0]), 32'hF);
`endif

    // Random scan traffic
    for (int i = 0; i < ND; i++) tb_last[i] = 7'h7F;
    for (int c = 0; c < 3000; c++) begin
      int            d;
      logic [ND-1:0] s;
      reset     = ($urandom_range(255) == 0);
      out_ready = $urandom_range(1);
      err_clr   = ($urandom_range(15) == 0);
      d         = $urandom_range(ND - 1);
      if ($urandom_range(1) == 0) tb_last[d] = POOL[$urandom_range(14)];
      if ($urandom_range(15) == 0) s = ND'($urandom);
      else begin
        s    = '0;
        s[d] = 1'b1;
      end
      drive($urandom_range(3) != 0, s, tb_last[d]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
